// File: rtl/bp_lce_starvation_ctrl.sv
// Starvation guard for the LCE: counts blocked cycles on the mem packet ports and withholds
// cache_req_ready_o so the LCE gets a free mem cycle once a port (or the aggregate) times out.
module bp_lce_starvation_ctrl #(
    parameter int ports_p       = 3,
    parameter int cnt_width_p   = 4,
    parameter int hold_cycles_p = 1,
    parameter int evt_width_p   = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [ports_p-1:0]     pkt_v_i,
    input  logic [ports_p-1:0]     pkt_yumi_i,
    input  logic [cnt_width_p-1:0] limit_i,
    input  logic                   mode_i,
    input  logic                   req_ready_i,
    input  logic                   evt_clear_i,
    output logic                   cache_req_ready_o,
    output logic [ports_p-1:0]     timeout_o,
    output logic                   starved_o,
    output logic [evt_width_p-1:0] evt_count_o,
    output logic [1:0]             state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STARVE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam int hold_w = (hold_cycles_p > 0) ? $clog2(hold_cycles_p + 1) : 1;
    localparam logic [hold_w-1:0] hold_init = hold_w'(hold_cycles_p);

    state_e                   state_q, state_d;
    logic [hold_w-1:0]        hold_q, hold_d;
    logic [evt_width_p-1:0]   evt_q, evt_d;
    logic [cnt_width_p-1:0]   cnt_q [ports_p];
    logic [cnt_width_p-1:0]   cnt_d [ports_p];
    logic                     mode_q;
    logic [ports_p-1:0]       blocked;
    logic                     any_blocked;
    logic                     any_to;
    logic                     evt_inc;

    function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] v);
        return (v == '1) ? v : v + cnt_width_p'(1);
    endfunction

    assign blocked     = pkt_v_i & ~pkt_yumi_i;
    assign any_blocked = |blocked;

    // A mode change clears every counter; the new mode starts counting the cycle after.
    always_comb begin
        for (int i = 0; i < ports_p; i++) begin
            cnt_d[i] = '0;
        end
        if (mode_i == mode_q) begin
            if (!mode_q) begin
                for (int i = 0; i < ports_p; i++) begin
                    cnt_d[i] = blocked[i] ? sat_inc(cnt_q[i]) : '0;
                end
            end else begin
                cnt_d[0] = any_blocked ? sat_inc(cnt_q[0]) : '0;
            end
        end
    end

    always_comb begin
        timeout_o = '0;
        for (int i = 0; i < ports_p; i++) begin
            timeout_o[i] = (limit_i != '0) && (cnt_q[i] >= limit_i);
        end
    end

    assign any_to = |timeout_o;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        evt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_to) begin
                    state_d = STARVE;
                    evt_inc = 1'b1;
                end
            end
            STARVE: begin
                if (!any_blocked) begin
                    if (hold_cycles_p == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        hold_d  = hold_init;
                    end
                end
            end
            HOLD: begin
                // A fresh timeout during hysteresis is a new starvation event.
                if (any_to) begin
                    state_d = STARVE;
                    evt_inc = 1'b1;
                end else if (hold_q <= hold_w'(1)) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - hold_w'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        evt_d = evt_q;
        if (evt_clear_i) begin
            evt_d = '0;
        end else if (evt_inc && (evt_q != '1)) begin
            evt_d = evt_q + evt_width_p'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            hold_q  <= '0;
            evt_q   <= '0;
            mode_q  <= 1'b0;
            for (int i = 0; i < ports_p; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            evt_q   <= evt_d;
            mode_q  <= mode_i;
            for (int i = 0; i < ports_p; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cache_req_ready_o = reset_n_i & req_ready_i & (state_q == IDLE) & ~any_to;
    assign starved_o         = (state_q != IDLE);
    assign evt_count_o       = evt_q;
    assign state_o           = state_q;

endmodule
